// File: rtl/rx_stream_arbiter.sv
// Round-robin merge of per-lane 27-bit receiver FIFOs into one tagged 32-bit readout stream.
// Bursts per grant are capped at MAX_BURST; one output word is held in a register.
module rx_stream_arbiter #(
  parameter int NUM_RX    = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                 BUS_CLK,
  input  logic                 RESET_N,
  input  logic [NUM_RX-1:0]    LANE_EN,
  input  logic [27*NUM_RX-1:0] RX_DATA,
  input  logic [NUM_RX-1:0]    RX_EMPTY,
  output logic [NUM_RX-1:0]    RX_READ,
  output logic [31:0]          OUT_DATA,
  output logic                 OUT_EMPTY,
  input  logic                 OUT_READ,
  output logic [2:0]           GRANT,
  output logic [31:0]          OUT_CNT
);
  typedef enum logic {IDLE, BURST} state_t;

  state_t            state;
  logic [7:0]        burst_cnt;
  logic [NUM_RX-1:0] req;
  logic              req_g, space, pop, found;
  logic [26:0]       data_g;
  logic [2:0]        next_grant;

  assign req   = LANE_EN & ~RX_EMPTY;
  assign space = OUT_EMPTY | OUT_READ;
  assign pop   = (state == BURST) && req_g && space;

  // Granted-lane request/data mux and pop strobe decode
  always_comb begin
    req_g   = 1'b0;
    data_g  = '0;
    RX_READ = '0;
    for (int i = 0; i < NUM_RX; i++) begin
      if (GRANT == 3'(i)) begin
        req_g      = req[i];
        data_g     = RX_DATA[27*i +: 27];
        RX_READ[i] = pop;
      end
    end
  end

  // Search starts at GRANT+1 and wraps; outer loop order makes the nearest requester win
  always_comb begin
    next_grant = GRANT;
    found      = 1'b0;
    for (int k = 1; k <= NUM_RX; k++) begin
      for (int j = 0; j < NUM_RX; j++) begin
        if (!found && req[j] &&
            ((int'(GRANT) + k == j) || (int'(GRANT) + k == j + NUM_RX))) begin
          found      = 1'b1;
          next_grant = 3'(j);
        end
      end
    end
  end

  always_ff @(posedge BUS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      GRANT     <= 3'(NUM_RX - 1);
      burst_cnt <= '0;
      OUT_EMPTY <= 1'b1;
      OUT_DATA  <= '0;
      OUT_CNT   <= '0;
    end else begin
      if (OUT_READ && !OUT_EMPTY)
        OUT_CNT <= OUT_CNT + 32'd1;

      // A pop refills the register even when the held word leaves this same cycle
      if (pop) begin
        OUT_DATA  <= {2'b01, GRANT, data_g};
        OUT_EMPTY <= 1'b0;
      end else if (OUT_READ) begin
        OUT_EMPTY <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (found) begin
            GRANT     <= next_grant;
            burst_cnt <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (pop) begin
            burst_cnt <= burst_cnt + 8'd1;
            if (burst_cnt == 8'(MAX_BURST - 1))
              state <= IDLE;
          end else if (!req_g) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_stream_arbiter.sv
// Bench for rx_stream_arbiter: lane FIFO models feed the DUT, expected words are queued
// at stimulus time and compared as the consumer accepts them.
module tb_rx_stream_arbiter;
  localparam int NRX = 4;
  localparam int MB  = 4;

  logic               BUS_CLK = 1'b0;
  logic               RESET_N = 1'b0;
  logic [NRX-1:0]     LANE_EN = '0;
  logic [27*NRX-1:0]  RX_DATA;
  logic [NRX-1:0]     RX_EMPTY;
  logic [NRX-1:0]     RX_READ;
  logic [31:0]        OUT_DATA;
  logic               OUT_EMPTY;
  logic               OUT_READ = 1'b0;
  logic [2:0]         GRANT;
  logic [31:0]        OUT_CNT;

  rx_stream_arbiter #(.NUM_RX(NRX), .MAX_BURST(MB)) dut (
    .BUS_CLK(BUS_CLK), .RESET_N(RESET_N), .LANE_EN(LANE_EN), .RX_DATA(RX_DATA),
    .RX_EMPTY(RX_EMPTY), .RX_READ(RX_READ), .OUT_DATA(OUT_DATA), .OUT_EMPTY(OUT_EMPTY),
    .OUT_READ(OUT_READ), .GRANT(GRANT), .OUT_CNT(OUT_CNT)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  logic [26:0] lq [NRX][$];
  logic [31:0] exp_q [$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  function automatic logic [26:0] wd(input int l, input int j);
    return 27'(32'h0100000 + l * 256 + j);
  endfunction

  function automatic logic [31:0] ew(input int l, input int j);
    return {2'b01, 3'(l), wd(l, j)};
  endfunction

  task automatic update_lanes();
    for (int i = 0; i < NRX; i++) begin
      RX_EMPTY[i]         = (lq[i].size() == 0);
      RX_DATA[27*i +: 27] = (lq[i].size() != 0) ? lq[i][0] : 27'd0;
    end
  endtask

  // One clock: sample/score before the edge, then apply lane pops after it
  task automatic cyc(output logic [NRX-1:0] rd, output logic acc);
    #1;
    rd  = RX_READ;
    acc = OUT_READ && !OUT_EMPTY;
    chk("onehot", 32'($countones(rd) <= 1), 32'd1);
    chk("dis_rd", 32'(rd & ~LANE_EN), 32'd0);
    chk("rd_empty", 32'(rd & RX_EMPTY), 32'd0);
    if (acc) begin
      if (exp_q.size() == 0) chk("sb_extra", OUT_DATA, 32'h0);
      else chk("sb_word", OUT_DATA, exp_q.pop_front());
    end
    @(posedge BUS_CLK);
    #1;
    for (int i = 0; i < NRX; i++)
      if (rd[i] && lq[i].size() != 0) void'(lq[i].pop_front());
    update_lanes();
  endtask

  task automatic do_reset();
    logic [NRX-1:0] rd;
    logic acc;
    RESET_N  = 1'b0;
    LANE_EN  = '0;
    OUT_READ = 1'b0;
    for (int i = 0; i < NRX; i++) lq[i].delete();
    exp_q.delete();
    update_lanes();
    cyc(rd, acc);
    cyc(rd, acc);
    RESET_N = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    logic [NRX-1:0] rd;
    logic acc;
    for (int k = 0; k < budget && (exp_q.size() != 0 || !OUT_EMPTY); k++) cyc(rd, acc);
    chk(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [NRX-1:0] rd;
    logic acc;
    int first, last, nrd, afirst, alast, nacc;

    update_lanes();
    #12;
    chk("rst_empty", 32'(OUT_EMPTY), 32'd1);
    chk("rst_data", OUT_DATA, 32'd0);
    chk("rst_cnt", OUT_CNT, 32'd0);
    chk("rst_grant", 32'(GRANT), 32'd3);
    chk("rst_rd", 32'(RX_READ), 32'd0);

    // Single lane: lane 2 only, three words
    do_reset();
    LANE_EN  = 4'b0100;
    OUT_READ = 1'b1;
    for (int j = 0; j < 3; j++) begin
      lq[2].push_back(wd(2, j));
      exp_q.push_back(ew(2, j));
    end
    update_lanes();
    first = -1; last = -1; nrd = 0; afirst = -1; alast = -1; nacc = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(rd, acc);
      if (rd != 0) begin
        chk("sl_rd", 32'(rd), 32'h4);
        if (first < 0) first = k;
        last = k;
        nrd++;
      end
      if (acc) begin
        if (afirst < 0) afirst = k;
        alast = k;
        nacc++;
      end
    end
    chk("sl_first_rd", first, 32'd1);
    chk("sl_nrd", nrd, 32'd3);
    chk("sl_rd_span", last - first, 32'd2);
    chk("sl_first_out", afirst, 32'd2);
    chk("sl_nout", nacc, 32'd3);
    chk("sl_out_span", alast - afirst, 32'd2);
    chk("sl_cnt", OUT_CNT, 32'd3);
    chk("sl_grant", 32'(GRANT), 32'd2);
    chk("sl_idle_empty", 32'(OUT_EMPTY), 32'd1);
    chk("sl_left", exp_q.size(), 32'd0);

    // Fairness: 4 lanes x 10 words, bursts of 4 then a final round of 2
    do_reset();
    LANE_EN  = '1;
    OUT_READ = 1'b1;
    for (int l = 0; l < NRX; l++)
      for (int j = 0; j < 10; j++) lq[l].push_back(wd(l, j));
    for (int r = 0; r < 3; r++)
      for (int l = 0; l < NRX; l++)
        for (int j = 0; j < ((r < 2) ? 4 : 2); j++) exp_q.push_back(ew(l, r * 4 + j));
    update_lanes();
    first = -1; last = -1;
    for (int k = 0; k < 200 && (exp_q.size() != 0 || !OUT_EMPTY); k++) begin
      cyc(rd, acc);
      if (rd != 0) begin
        if (first < 0) first = k;
        last = k;
      end
    end
    chk("fair_left", exp_q.size(), 32'd0);
    chk("fair_span", last - first + 1, 32'd54);
    chk("fair_cnt", OUT_CNT, 32'd40);

    // Back-pressure on lane 0
    do_reset();
    LANE_EN  = 4'b0001;
    OUT_READ = 1'b0;
    for (int j = 0; j < 3; j++) begin
      lq[0].push_back(wd(0, j));
      exp_q.push_back(ew(0, j));
    end
    update_lanes();
    nrd = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(rd, acc);
      if (rd != 0) nrd++;
    end
    chk("bp_one_pop", nrd, 32'd1);
    chk("bp_held", 32'(OUT_EMPTY), 32'd0);
    chk("bp_rd_low", 32'(RX_READ), 32'd0);
    OUT_READ = 1'b1;
    cyc(rd, acc);
    chk("bp_same_cyc_rd", 32'(rd), 32'h1);
    chk("bp_same_cyc_acc", 32'(acc), 32'd1);
    OUT_READ = 1'b0;
    chk("bp_refilled", 32'(OUT_EMPTY), 32'd0);
    cyc(rd, acc);
    chk("bp_hold_rd", 32'(rd), 32'd0);
    OUT_READ = 1'b1;
    drain("bp_left", 20);
    chk("bp_cnt", OUT_CNT, 32'd3);

    // Lane 1 disabled after two pops; lane 2 takes the next grant
    do_reset();
    LANE_EN  = 4'b0110;
    OUT_READ = 1'b1;
    for (int j = 0; j < 4; j++) lq[1].push_back(wd(1, j));
    for (int j = 0; j < 2; j++) lq[2].push_back(wd(2, j));
    exp_q.push_back(ew(1, 0));
    exp_q.push_back(ew(1, 1));
    exp_q.push_back(ew(2, 0));
    exp_q.push_back(ew(2, 1));
    update_lanes();
    nrd = 0;
    for (int k = 0; k < 10 && nrd < 2; k++) begin
      cyc(rd, acc);
      if (rd[1]) nrd++;
    end
    chk("dis_pops", nrd, 32'd2);
    LANE_EN = 4'b0100;
    cyc(rd, acc);
    chk("dis_no_pop", 32'(rd), 32'd0);
    drain("dis_left", 20);
    chk("dis_grant", 32'(GRANT), 32'd2);
    chk("dis_lane1_kept", lq[1].size(), 32'd2);
    chk("dis_cnt", OUT_CNT, 32'd4);

    // Asynchronous reset while a word is held
    do_reset();
    LANE_EN  = '1;
    OUT_READ = 1'b0;
    for (int j = 0; j < 3; j++) lq[2].push_back(wd(2, j));
    exp_q.push_back(ew(2, 0));
    update_lanes();
    for (int k = 0; k < 4; k++) cyc(rd, acc);
    chk("mr_held", 32'(OUT_EMPTY), 32'd0);
    chk("mr_grant_pre", 32'(GRANT), 32'd2);
    lq[1].push_back(wd(1, 0));
    update_lanes();
    #2;
    RESET_N = 1'b0;
    #1;
    chk("mr_empty", 32'(OUT_EMPTY), 32'd1);
    chk("mr_rd", 32'(RX_READ), 32'd0);
    chk("mr_cnt", OUT_CNT, 32'd0);
    chk("mr_grant", 32'(GRANT), 32'd3);
    chk("mr_data", OUT_DATA, 32'd0);
    void'(exp_q.pop_front());
    RESET_N = 1'b1;
    exp_q.push_back(ew(1, 0));
    exp_q.push_back(ew(2, 1));
    exp_q.push_back(ew(2, 2));
    OUT_READ = 1'b1;
    drain("mr_left", 30);
    chk("mr_cnt_after", OUT_CNT, 32'd3);
    chk("mr_grant_after", 32'(GRANT), 32'd2);

    // Spurious consumer read while empty
    OUT_READ = 1'b0;
    cyc(rd, acc);
    OUT_READ = 1'b1;
    cyc(rd, acc);
    OUT_READ = 1'b0;
    cyc(rd, acc);
    chk("sp_cnt", OUT_CNT, 32'd3);
    chk("sp_empty", 32'(OUT_EMPTY), 32'd1);
    chk("sp_grant", 32'(GRANT), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rx_stream_arbiter.md
# rx_stream_arbiter

Round-robin arbiter that merges the 27-bit output FIFOs of up to eight receiver lanes into one 32-bit readout stream on BUS_CLK. Each word is tagged with its lane number. Per-lane bursts are bounded so that a busy lane cannot starve the others. The block sits between the per-lane receiver FIFOs and the shared readout FIFO/SRAM interface.

## Interface
Parameters:
- NUM_RX, 4: number of receiver lanes; legal range 1..8.
- MAX_BURST, 16: maximum words popped from one lane per grant; legal range 1..255.

Ports:
- BUS_CLK  input  1  sole clock; all logic is on the rising edge.
- RESET_N  input  1  reset, asynchronous and active-low; deassertion is synchronised externally.
- LANE_EN  input  NUM_RX  per-lane enable; a disabled lane is never granted or popped.
- RX_DATA  input  27*NUM_RX  lane i occupies [27i+26:27i]; first-word-fall-through, valid whenever RX_EMPTY[i]=0.
- RX_EMPTY  input  NUM_RX  lane FIFO empty flags.
- RX_READ  output  NUM_RX  pop strobes, one per lane; at most one bit is high in any cycle.
- OUT_DATA  output  32  {2'b01, lane[2:0], rx_word[26:0]}.
- OUT_EMPTY  output  1  high when no word is held in OUT_DATA.
- OUT_READ  input  1  consumer pop; ignored while OUT_EMPTY=1.
- GRANT  output  3  lane that currently holds, or last held, the grant.
- OUT_CNT  output  32  words delivered (OUT_READ accepted); wraps modulo 2^32.

## Operation
- req[i] = LANE_EN[i] & ~RX_EMPTY[i].
- space = OUT_EMPTY | OUT_READ. A word leaving and a word entering in the same cycle is legal.
- Two states, IDLE and BURST.
- IDLE:
  - If any req[i] is high, GRANT <= the first requesting lane searched cyclically from GRANT+1; burst_cnt <= 0; go to BURST.
  - Nothing is popped while in IDLE.
  - If no lane requests, stay in IDLE and hold GRANT.
- BURST:
  - RX_READ[GRANT] = req[GRANT] & space. This is combinational and includes the path from OUT_READ.
  - On a pop, the output register loads {2'b01, GRANT, RX_DATA[GRANT]} on the next edge and burst_cnt increments.
  - Go to IDLE when req[GRANT]=0, or on the pop that brings burst_cnt to MAX_BURST.
  - If space=0 and req[GRANT]=1, stay in BURST without popping. Back-pressure does not forfeit the grant.
- LANE_EN[GRANT] falling mid-burst:
  - No pop happens in that cycle; go to IDLE.
  - A word already captured is still delivered.
- The output register holds exactly one word.
  - OUT_EMPTY falls on the edge after a pop.
  - OUT_EMPTY rises on the edge after OUT_READ, unless a new pop happens in the same cycle.
- OUT_CNT increments on OUT_READ & ~OUT_EMPTY.
- Width rules:
  - With NUM_RX<8, the unused upper bits of the lane tag are zero.
  - burst_cnt is 8 bits.
  - Lanes with index >= NUM_RX do not exist.
- Reset values, asserted asynchronously while RESET_N=0:
  - State IDLE.
  - GRANT = NUM_RX-1, so the first search starts at lane 0.
  - burst_cnt = 0, OUT_EMPTY = 1, OUT_DATA = 0, OUT_CNT = 0.
  - RX_READ = 0 (forced low by state IDLE).
- Reset mid-burst: the held output word is discarded. Lane FIFOs are not touched and keep any unpopped words.

## Timing
- Arbitration costs one cycle: req seen in IDLE at edge t, first RX_READ in cycle t+1, OUT_EMPTY low after edge t+2.
- Sustained throughput with OUT_READ held high: MAX_BURST words per MAX_BURST+1 cycles, with one IDLE bubble per grant.
- RX_READ and OUT_READ may share a cycle; the delivered word and the replacement both transfer in that cycle.
- Lane order is strict round-robin over requesting lanes. Lanes that do not request are skipped with no extra cycles.

## Test plan
- Single lane: NUM_RX=4, only lane 2 enabled, 3 words A,B,C, OUT_READ=1.
  - OUT_DATA = {2'b01, 3'd2, A}, then B, then C on consecutive cycles.
  - RX_READ = 4'b0100 for exactly 3 cycles; OUT_CNT=3; returns to IDLE.
- Fairness: all 4 lanes with 10 words each, MAX_BURST=4, OUT_READ=1.
  - Tag sequence is 4×L0, 4×L1, 4×L2, 4×L3, 4×L0, …, with one empty cycle between bursts.
  - 40 words total; no lane gap longer than 3 bursts.
- Back-pressure: OUT_READ=0 with lane 0 full.
  - Exactly one pop, then RX_READ=0 and OUT_EMPTY=0 held.
  - After OUT_READ=1 for 1 cycle, the next word loads in the same cycle and burst_cnt=2.
- Lane disable mid-burst: clear LANE_EN[1] after 2 pops with lane 1 still non-empty.
  - No further RX_READ[1]; the second word is still delivered.
  - The next grant goes to lane 2 if it requests.
- Reset mid-burst: assert RESET_N=0 asynchronously while OUT_EMPTY=0.
  - Immediately OUT_EMPTY=1, RX_READ=0, OUT_CNT=0, GRANT=NUM_RX-1.
  - After release, the first grant goes to the lowest requesting lane.
- Spurious read: pulse OUT_READ while OUT_EMPTY=1 → OUT_CNT unchanged, no state change.
